// File: rtl/seg_pkg.sv
// Shared 7-segment patterns (active-low, bit 6..0 = g..a) and the converter FSM encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Number of BCD digits needed to hold any in_w-bit unsigned value.
  function automatic int bcd_digits(input int in_w);
    return (in_w * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; codes 10-15 show blank.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/speed_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving a multi-digit 7-segment display.
// Valid/ready is not used: a new conversion starts whenever speed differs from the last converted value.
module speed_bcd_display
  import seg_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       speed,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  ovf,
  output state_e                dbg_state
);

  localparam int NB = bcd_digits(IN_W);
  localparam int BW = 4 * NB;
  localparam int CW = $clog2(IN_W + 1);

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      ovf_q, ovf_d;
  logic [DIGITS-1:0][6:0]    seg_q, seg_d;
  logic [IN_W-1:0]           last_q, last_d;
  logic [IN_W-1:0]           sh_q, sh_d;
  logic [BW-1:0]             bcd_q, bcd_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [BW-1:0]             bcd_adj;
  logic [DIGITS-1:0][3:0]    nib;
  logic [DIGITS-1:0][6:0]    dec_seg;
  logic [DIGITS-1:0][6:0]    disp;
  logic [DIGITS-1:0][6:0]    seg_rst;
  logic                      hi_nz;
  logic                      seen;

  // Display digits beyond the BCD register width read as zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k < NB) begin : g_real
      assign nib[k] = bcd_q[4*k +: 4];
    end else begin : g_zero
      assign nib[k] = 4'd0;
    end
    seg7_decode u_dec (
      .bcd_i (nib[k]),
      .seg_o (dec_seg[k])
    );
    assign seg_rst[k] = (k == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero BCD digit that has no display position means overflow.
  always_comb begin
    hi_nz = 1'b0;
    for (int i = DIGITS; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) hi_nz = 1'b1;
    end
  end

  always_comb begin
    seen = 1'b0;
    disp = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (nib[k] != 4'd0) seen = 1'b1;
      if (hi_nz)                                   disp[k] = SEG_DASH;
      else if (BLANK_LZ != 0 && !seen && k != 0)   disp[k] = SEG_BLANK;
      else                                         disp[k] = dec_seg[k];
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    last_d  = last_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (speed != last_q) begin
          sh_d    = speed;
          last_d  = speed;
          bcd_d   = '0;
          cnt_d   = CW'(IN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], sh_q[IN_W-1]};
        sh_d  = {sh_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        seg_d   = disp;
        ovf_d   = hi_nz;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= seg_rst;
      last_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seg       = seg_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_speed_bcd_display.sv
// Bench for speed_bcd_display: two instances (blanking on/off) against a decimal-arithmetic display model.
module tb_speed_bcd_display;
  import seg_pkg::*;

  localparam int IN_W   = 16;
  localparam int DIGITS = 4;
  localparam int SW     = 7 * DIGITS;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IN_W-1:0] speed = '0;
  always #5 clk = ~clk;

  logic [SW-1:0] seg_a, seg_b;
  logic          busy_a, busy_b, ovf_a, ovf_b;
  state_e        st_a, st_b;

  speed_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .speed(speed),
    .seg(seg_a), .busy(busy_a), .ovf(ovf_a), .dbg_state(st_a)
  );

  speed_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .speed(speed),
    .seg(seg_b), .busy(busy_b), .ovf(ovf_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [IN_W-1:0] exp_q[$];
  int unsigned shown = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_seg(input int unsigned v, input bit blz);
    logic [SW-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    if (v >= 10000) return {DIGITS{7'b0111111}};
    for (int k = 0; k < DIGITS; k++) begin
      if (blz && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
      else                       r[7*k +: 7] = SEG_TAB[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit model_ovf(input int unsigned v);
    return v >= 10000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_display(input string tag, input int unsigned v);
    check({tag, "_seg"},    seg_a, model_seg(v, 1'b1));
    check({tag, "_seg_nb"}, seg_b, model_seg(v, 1'b0));
    check({tag, "_ovf"},    ovf_a, model_ovf(v));
    check({tag, "_ovf_nb"}, ovf_b, model_ovf(v));
  endtask

  // Counts busy edges (pre already elapsed) and expects the next queued value afterwards.
  task automatic wait_conv(input int pre);
    int cnt;
    int unsigned v;
    cnt = pre;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy_a) break;
      cnt++;
      check("seg_hold", seg_a, model_seg(shown, 1'b1));
    end
    check("busy_cycles", cnt, 17);
    check("busy_nb", busy_b, busy_a);
    check("state_idle", st_a, ST_IDLE);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      v = shown;
    end else begin
      v = exp_q.pop_front();
    end
    check_display("conv", v);
    shown = v;
  endtask

  task automatic issue(input int unsigned v);
    speed = IN_W'(v);
    exp_q.push_back(IN_W'(v));
    wait_conv(0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned v;
    rst = 1'b1;
    speed = '0;
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_state", st_a, ST_IDLE);
    check_display("rst", 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", busy_a, 0);
      check("idle_seg", seg_a, model_seg(0, 1'b1));
    end
    check("idle_seg_nb", seg_b, model_seg(0, 1'b0));

    issue(1234);
    issue(7);
    issue(9999);
    issue(10000);
    issue(65535);
    issue(0);

    // Value change mid-conversion is ignored, then picked up by the next IDLE compare.
    speed = 16'd45;
    exp_q.push_back(16'd45);
    tick();
    tick();
    check("mid_busy", busy_a, 1);
    speed = 16'd99;
    wait_conv(2);
    exp_q.push_back(16'd99);
    wait_conv(0);

    // Reset during the shift phase aborts the conversion.
    speed = 16'd500;
    tick();
    check("abort_busy_start", busy_a, 1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_state", st_a, ST_IDLE);
    check_display("abort", 0);
    shown = 0;
    exp_q.push_back(16'd500);
    wait_conv(0);

    for (int i = 0; i < 25; i++) begin
      do begin
        if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 120);
        else                           v = $urandom_range(0, 65535);
      end while (v == shown);
      issue(v);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
